// File: rtl/qtable_writer_pkg.sv
// Constants shared by the Q-table update path (Bellman unit and write-back),
// plus the record carried down the update tracking line.
package qtable_writer_pkg;

  localparam int L_WIDTH      = 4;
  localparam int Q_WIDTH      = 16;
  localparam int S_WIDTH      = 8;
  localparam int N_ROAD       = 4;
  localparam int N_LEVEL      = 2 ** (L_WIDTH / 2);
  localparam int A_ROAD_WIDTH = 2;
  localparam int A_DUR_WIDTH  = L_WIDTH / 2;
  localparam int A_WIDTH      = A_ROAD_WIDTH + A_DUR_WIDTH;
  localparam int D_WIDTH      = Q_WIDTH * N_LEVEL;

  typedef struct packed {
    logic [S_WIDTH-1:0]      addr;
    logic [A_ROAD_WIDTH-1:0] road;
    logic [A_DUR_WIDTH-1:0]  lane;
  } trk_t;

  localparam int TRK_W = $bits(trk_t);

  function automatic logic [N_ROAD-1:0] road_dec(input logic [A_ROAD_WIDTH-1:0] r);
    road_dec    = '0;
    road_dec[r] = 1'b1;
  endfunction

  function automatic logic [N_LEVEL-1:0] lane_dec(input logic [A_DUR_WIDTH-1:0] l);
    lane_dec    = '0;
    lane_dec[l] = 1'b1;
  endfunction

endpackage

// File: rtl/qtable_writer_pipe_delay.sv
// Fixed-depth delay line with a reset-cleared valid bit per stage; every stage
// is exposed so the caller can compare against all in-flight entries.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [DEPTH-1:0][WIDTH-1:0]  stage_data
);

  logic [DEPTH-1:0]            vld_d, vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d, data_q;

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_valid;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Payload is qualified by the valid bit, so only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
    data_q <= data_d;
  end

  assign stage_valid = vld_q;
  assign stage_data  = data_q;

endmodule

// File: rtl/qtable_writer.sv
// Write-back stage of the Q-table update path: tracks issued updates, captures
// the Bellman result when it arrives and strobes one lane of one road's BRAM row.
module qtable_writer
  import qtable_writer_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      upd_valid,
  input  logic [S_WIDTH-1:0]        upd_addr,
  input  logic [A_WIDTH-1:0]        upd_act,
  input  logic signed [Q_WIDTH-1:0] q_new,
  input  logic [S_WIDTH-1:0]        probe_addr,
  output logic [N_ROAD-1:0]         wr_en,
  output logic [S_WIDTH-1:0]        wr_addr,
  output logic [N_LEVEL-1:0]        wr_lane_we,
  output logic [D_WIDTH-1:0]        wr_data,
  output logic                      hazard,
  output logic                      busy,
  output logic [15:0]               wr_count
);

  trk_t                           in_trk;
  logic [LATENCY-1:0]             stg_vld;
  logic [LATENCY-1:0][TRK_W-1:0]  stg_data;
  trk_t                           stg_trk [LATENCY];
  trk_t                           last_trk;

  assign in_trk.addr = upd_addr;
  assign in_trk.road = upd_act[A_WIDTH-1:A_DUR_WIDTH];
  assign in_trk.lane = upd_act[A_DUR_WIDTH-1:0];

  pipe_delay #(
    .WIDTH (TRK_W),
    .DEPTH (LATENCY)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (upd_valid),
    .in_data     (in_trk),
    .stage_valid (stg_vld),
    .stage_data  (stg_data)
  );

  for (genvar i = 0; i < LATENCY; i++) begin : g_stg
    assign stg_trk[i] = stg_data[i];
  end

  assign last_trk = stg_trk[LATENCY-1];

  logic                 wv_d, wv_q;
  logic [N_ROAD-1:0]    wr_en_d, wr_en_q;
  logic [N_LEVEL-1:0]   wr_lane_we_d, wr_lane_we_q;
  logic [S_WIDTH-1:0]   wr_addr_d, wr_addr_q;
  logic [D_WIDTH-1:0]   wr_data_d, wr_data_q;
  logic [15:0]          wr_count_d, wr_count_q;

  // The last tracking stage lines up with q_new; register it into the strobe.
  always_comb begin
    wv_d         = stg_vld[LATENCY-1];
    wr_en_d      = '0;
    wr_lane_we_d = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_count_d   = wr_count_q;
    if (stg_vld[LATENCY-1]) begin
      wr_en_d      = road_dec(last_trk.road);
      wr_lane_we_d = lane_dec(last_trk.lane);
      wr_addr_d    = last_trk.addr;
      wr_data_d    = {N_LEVEL{q_new}};
      wr_count_d   = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wv_q         <= 1'b0;
      wr_en_q      <= '0;
      wr_lane_we_q <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_count_q   <= '0;
    end else begin
      wv_q         <= wv_d;
      wr_en_q      <= wr_en_d;
      wr_lane_we_q <= wr_lane_we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Road is ignored: the Bellman read fetches all four roads of a row at once.
  always_comb begin
    hazard = wv_q && (wr_addr_q == probe_addr);
    for (int i = 0; i < LATENCY; i++)
      if (stg_vld[i] && (stg_trk[i].addr == probe_addr)) hazard = 1'b1;
  end

  assign busy       = (|stg_vld) | wv_q;
  assign wr_en      = wr_en_q;
  assign wr_lane_we = wr_lane_we_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_count   = wr_count_q;

endmodule
